// File: rtl/fifo_64to32_unpack_pkg.sv
// Shared definitions for the 64<->32 FIFO width converters: state encoding and half-select
// constants, also used by fifo_32to64_pack.
package fifo_64to32_unpack_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StFirst  = 2'd1,
      StSecond = 2'd2
   } unpack_state_e;

   localparam logic HalfLow  = 1'b0;
   localparam logic HalfHigh = 1'b1;

   function automatic logic [31:0] select_half(input logic [63:0] word, input logic sel);
      return (sel == HalfHigh) ? word[63:32] : word[31:0];
   endfunction

endpackage

// File: rtl/fifo_64to32_unpack.sv
// Pops 64-bit words from a FWFT FIFO and emits them as two 32-bit valid/ready beats.
// Define FIFO_UNPACK_CNT_EN to add the o_beat_cnt transfer counter.
module fifo_64to32_unpack
   import fifo_64to32_unpack_pkg::*;
#(
   parameter bit          HIGH_FIRST = 1'b1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [63:0]      i_fifo_data,
   input  logic             i_fifo_empty,
   output logic             o_fifo_rd_en,
   input  logic             i_flush,
   output logic [31:0]      o_data,
   output logic             o_valid,
`ifdef FIFO_UNPACK_CNT_EN
   output logic [CNT_W-1:0] o_beat_cnt,
`endif
   input  logic             i_ready
);

   localparam logic FirstSel  = HIGH_FIRST ? HalfHigh : HalfLow;
   localparam logic SecondSel = ~FirstSel;

   unpack_state_e state_q;
   logic [63:0]   hold_q;
   logic [31:0]   data_q;
   logic          valid_q;
   logic          pop;

   // Pop from IDLE, or from SECOND when its beat is being accepted (no bubble).
   always_comb begin
      pop = 1'b0;
      if (!rst && !i_flush && !i_fifo_empty) begin
         unique case (state_q)
            StIdle:   pop = 1'b1;
            StSecond: pop = i_ready;
            default:  pop = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         hold_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (i_flush) begin
         state_q <= StIdle;
         valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  hold_q  <= i_fifo_data;
                  data_q  <= select_half(i_fifo_data, FirstSel);
                  valid_q <= 1'b1;
                  state_q <= StFirst;
               end
            end
            StFirst: begin
               if (i_ready) begin
                  data_q  <= select_half(hold_q, SecondSel);
                  state_q <= StSecond;
               end
            end
            StSecond: begin
               if (i_ready) begin
                  if (pop) begin
                     hold_q  <= i_fifo_data;
                     data_q  <= select_half(i_fifo_data, FirstSel);
                     state_q <= StFirst;
                  end else begin
                     valid_q <= 1'b0;
                     state_q <= StIdle;
                  end
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

`ifdef FIFO_UNPACK_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // A beat presented during flush is dropped, not transferred.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (valid_q && i_ready && !i_flush) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign o_beat_cnt = cnt_q;
`endif

   assign o_fifo_rd_en = pop;
   assign o_data       = data_q;
   assign o_valid      = valid_q;

endmodule

// File: tb/tb_fifo_64to32_unpack.sv
// Directed bench for fifo_64to32_unpack with a queue-based FWFT FIFO model per instance.
module tb_fifo_64to32_unpack;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        ready;
   logic [63:0] fdata, fdata_lo;
   logic        fempty, fempty_lo;
   logic        rd_en, rd_en_lo;
   logic [31:0] data, data_lo;
   logic        valid, valid_lo;
`ifdef FIFO_UNPACK_CNT_EN
   logic [15:0] cnt, cnt_lo;
`endif

   logic [63:0] q[$];
   logic [63:0] q_lo[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          pops     = 0;
   int          exp_cnt  = 0;

   always #5 clk = ~clk;

   fifo_64to32_unpack #(.HIGH_FIRST(1'b1), .CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_fifo_data  (fdata),
      .i_fifo_empty (fempty),
      .o_fifo_rd_en (rd_en),
      .i_flush      (flush),
      .o_data       (data),
      .o_valid      (valid),
`ifdef FIFO_UNPACK_CNT_EN
      .o_beat_cnt   (cnt),
`endif
      .i_ready      (ready)
   );

   fifo_64to32_unpack #(.HIGH_FIRST(1'b0), .CNT_W(16)) dut_lo (
      .clk          (clk),
      .rst          (rst),
      .i_fifo_data  (fdata_lo),
      .i_fifo_empty (fempty_lo),
      .o_fifo_rd_en (rd_en_lo),
      .i_flush      (flush),
      .o_data       (data_lo),
      .o_valid      (valid_lo),
`ifdef FIFO_UNPACK_CNT_EN
      .o_beat_cnt   (cnt_lo),
`endif
      .i_ready      (ready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_fifo();
      fempty    = (q.size() == 0);
      fdata     = fempty ? 64'h0 : q[0];
      fempty_lo = (q_lo.size() == 0);
      fdata_lo  = fempty_lo ? 64'h0 : q_lo[0];
   endtask

   // Advance one cycle; inputs change and outputs are sampled 1-2 time units after the edge.
   task automatic tick();
      logic p, p_lo;
      p    = rd_en;
      p_lo = rd_en_lo;
      @(posedge clk);
      #1;
      if (p) begin
         void'(q.pop_front());
         pops++;
      end
      if (p_lo) void'(q_lo.pop_front());
      drive_fifo();
      #1;
   endtask

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      ready = 1'b1;
      q.push_back(64'h1111_2222_3333_4444);
      drive_fifo();
      #1;
      check("rst_valid", valid, 0);
      check("rst_data", data, 0);
      check("rst_rd_en", rd_en, 0);
`ifdef FIFO_UNPACK_CNT_EN
      check("rst_cnt", cnt, 0);
`endif
      #20;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;

      // Single word, ready high
      check("t1_rd_en_idle", rd_en, 1);
      tick();
      check("t1_valid0", valid, 1);
      check("t1_beat0", data, 32'h1111_2222);
      check("t1_rd_en_first", rd_en, 0);
      tick();
      check("t1_beat1", data, 32'h3333_4444);
      check("t1_valid1", valid, 1);
      tick();
      check("t1_idle", valid, 0);
      check("t1_pops", pops, 1);
      exp_cnt += 2;

      // Three words back to back
      q.push_back(64'h0000_0001_0000_0002);
      q.push_back(64'h0000_0003_0000_0004);
      q.push_back(64'h0000_0005_0000_0006);
      drive_fifo();
      #1;
      tick();
      for (int i = 0; i < 6; i++) begin
         check("t2_valid", valid, 1);
         check("t2_beat", data, 32'(i + 1));
         tick();
      end
      check("t2_idle", valid, 0);
      check("t2_pops", pops, 4);
      exp_cnt += 6;
`ifdef FIFO_UNPACK_CNT_EN
      check("t2_cnt", cnt, 16'(exp_cnt));
`endif

      // Backpressure in FIRST
      ready = 1'b0;
      q.push_back(64'hAAAA_BBBB_CCCC_DDDD);
      drive_fifo();
      #1;
      tick();
      check("t3_beat0", data, 32'hAAAA_BBBB);
      tick();
      check("t3_hold1", data, 32'hAAAA_BBBB);
      check("t3_hold1_valid", valid, 1);
      tick();
      check("t3_hold2", data, 32'hAAAA_BBBB);
      check("t3_pops", pops, 5);
      ready = 1'b1;
      #1;
      tick();
      check("t3_beat1", data, 32'hCCCC_DDDD);
      tick();
      check("t3_idle", valid, 0);
      exp_cnt += 2;

      // Low half first
      q_lo.push_back(64'hDEAD_BEEF_0123_4567);
      drive_fifo();
      #1;
      tick();
      check("t4_beat0", data_lo, 32'h0123_4567);
      tick();
      check("t4_beat1", data_lo, 32'hDEAD_BEEF);
      tick();
      check("t4_idle", valid_lo, 0);

      // Flush in SECOND with FIFO non-empty
      q.push_back(64'h1234_5678_9ABC_DEF0);
      q.push_back(64'h0F0F_0F0F_F0F0_F0F0);
      drive_fifo();
      #1;
      tick();
      tick();
      check("t5_second", data, 32'h9ABC_DEF0);
      check("t5_rd_en_pre", rd_en, 1);
      flush = 1'b1;
      #1;
      check("t5_rd_en_flush", rd_en, 0);
      tick();
      flush = 1'b0;
      #1;
      check("t5_valid_after", valid, 0);
      check("t5_qsize", q.size(), 1);
      check("t5_rd_en_idle", rd_en, 1);
      tick();
      check("t5_next_beat0", data, 32'h0F0F_0F0F);
      tick();
      check("t5_next_beat1", data, 32'hF0F0_F0F0);
      tick();
      check("t5_idle", valid, 0);
      exp_cnt += 3;
`ifdef FIFO_UNPACK_CNT_EN
      check("t5_cnt", cnt, 16'(exp_cnt));
`endif

      // Reset while in FIRST
      ready = 1'b0;
      q.push_back(64'h5555_6666_7777_8888);
      q.push_back(64'h9999_AAAA_BBBB_CCCC);
      drive_fifo();
      #1;
      tick();
      check("t6_first", data, 32'h5555_6666);
      rst = 1'b1;
      #1;
      check("t6_rst_valid", valid, 0);
      check("t6_rst_rd_en", rd_en, 0);
`ifdef FIFO_UNPACK_CNT_EN
      check("t6_rst_cnt", cnt, 0);
`endif
      tick();
      check("t6_rst_no_pop", q.size(), 1);
      rst   = 1'b0;
      ready = 1'b1;
      #1;
      check("t6_rd_en_idle", rd_en, 1);
      tick();
      check("t6_beat0", data, 32'h9999_AAAA);
      tick();
      check("t6_beat1", data, 32'hBBBB_CCCC);
      tick();
      check("t6_idle", valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_64to32_unpack.md
# fifo_64to32_unpack

Read-side consumer for the 512x64 asynchronous FIFO, running in the read clock domain. It pops 64-bit words through the FIFO's first-word-fall-through read port. Each word is emitted as two 32-bit beats on a valid/ready stream, so a 32-bit datapath can drain a 64-bit link buffer at one beat per cycle with no bubbles.

## Interface
Parameters:
- HIGH_FIRST, 1, 1: emit i_fifo_data[63:32] first, then [31:0]; 0: reverse order.
- CNT_W, 16, width of the optional beat counter.

Ports:
- clk  in  1  single clock; the FIFO's clk_rd domain.
- rst  in  1  reset, asynchronous, active-high.
- i_fifo_data  in  64  FIFO head word; valid whenever i_fifo_empty==0.
- i_fifo_empty  in  1  FIFO empty flag.
- o_fifo_rd_en  out  1  pop strobe; next head is valid the following cycle.
- i_flush  in  1  synchronous drop of any held word.
- o_data  out  32  output beat.
- o_valid  out  1  beat valid.
- i_ready  in  1  consumer accepts the beat; transfer = o_valid & i_ready.
- o_beat_cnt  out  CNT_W  beats transferred; present only with FIFO_UNPACK_CNT_EN.

## Operation
- 64-bit hold register plus a 2-bit state register.
- IDLE: o_valid=0.
  - If i_fifo_empty==0, assert o_fifo_rd_en, load the hold register from i_fifo_data, go to FIRST.
- FIRST: o_valid=1, o_data = first half per HIGH_FIRST.
  - On transfer, go to SECOND; otherwise hold.
- SECOND: o_valid=1, o_data = second half.
  - On transfer with i_fifo_empty==0: assert o_fifo_rd_en, reload the hold register, go to FIRST (back-to-back, no bubble).
  - On transfer with i_fifo_empty==1: go to IDLE.
  - No transfer: hold; o_fifo_rd_en=0.
- o_fifo_rd_en is combinational from state, i_fifo_empty, i_ready and i_flush. It is never asserted when i_fifo_empty==1. It is forced to 0 while rst==1.
- i_flush has priority over everything.
  - Next state is IDLE and o_fifo_rd_en=0 in the same cycle.
  - A beat presented in the flush cycle is not counted as transferred, even if i_ready==1.
  - The FIFO is not popped, so the word already consumed is lost and the FIFO contents are untouched.
- The hold register is loaded only on a pop. o_data is stable while o_valid & ~i_ready.
- The stream never deasserts o_valid without a transfer, except on flush or reset.

## Timing
- Reset values: state=IDLE, o_valid=0, o_data=0, o_fifo_rd_en=0, o_beat_cnt=0.
- Latency: i_fifo_empty falls at cycle t (state IDLE) -> pop at t -> o_valid=1 at t+1.
- Throughput: 2 beats per 64-bit word; sustained 1 beat/cycle while the FIFO is non-empty and i_ready=1.
- Reset mid-word: the held word is discarded asynchronously and never re-read.
- Empty raised in the same cycle SECOND completes: no pop, go to IDLE; the next word is taken one cycle later from IDLE.
- o_data and o_valid are registered. Only o_fifo_rd_en is combinational.

## Configuration
- FIFO_UNPACK_CNT_EN defined:
  - o_beat_cnt exists and increments by 1 per transfer, wrapping modulo 2^CNT_W.
  - Cleared by rst only; i_flush does not clear it.
- Not defined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package/header: state encodings (IDLE=2'd0, FIRST=2'd1, SECOND=2'd2) and the beat-half select constants. The sibling packer stage fifo_32to64_pack reuses them.
- No sub-module; a single always block for state/hold, plus a combinational pop/output decode.

## Test plan
- Reset then preload 0x1111_2222_3333_4444, i_ready=1 -> beats 0x1111_2222, 0x3333_4444 on consecutive cycles; exactly one o_fifo_rd_en pulse.
- Three words preloaded, i_ready=1 -> 6 beats in 6 consecutive cycles, o_valid never drops; with CNT_EN, o_beat_cnt=6.
- i_ready toggled 1,0,0,1 during FIRST -> o_data holds 0xAAAA_BBBB unchanged until accepted; no extra pop.
- HIGH_FIRST=0, word 0xDEAD_BEEF_0123_4567 -> 0x0123_4567 then 0xDEAD_BEEF.
- i_flush asserted in SECOND with the FIFO non-empty -> o_valid=0 next cycle; no pop in the flush cycle; the next word is emitted from IDLE afterwards.
- rst pulsed while in FIRST -> o_valid=0 immediately and o_fifo_rd_en=0 during reset; o_beat_cnt=0.
